// File: rtl/jt49_exp_mix.sv
// Time-multiplexed log-to-linear volume expander and mixer.
// Scans CH channel levels through a 1.5 dB/step ROM and sums them into dout.
module jt49_exp_mix #(
  parameter int CH = 3,
  parameter int SW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic [5*CH-1:0]   lvl,
  input  logic [CH-1:0]     mode,
  input  logic [CH-1:0]     mute,
  output logic [10*CH-1:0]  ch_lin,
  output logic [SW-1:0]     dout,
  output logic              sample
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [IW-1:0] LAST = IW'(CH - 1);

  // 1023 * 2^((n-31)/4), rounded half up
  function automatic logic [9:0] lin_tab(input logic [4:0] m);
    logic [9:0] t;
    case (m)
      5'd0:  t = 10'd0;
      5'd1:  t = 10'd6;
      5'd2:  t = 10'd7;
      5'd3:  t = 10'd8;
      5'd4:  t = 10'd10;
      5'd5:  t = 10'd11;
      5'd6:  t = 10'd13;
      5'd7:  t = 10'd16;
      5'd8:  t = 10'd19;
      5'd9:  t = 10'd23;
      5'd10: t = 10'd27;
      5'd11: t = 10'd32;
      5'd12: t = 10'd38;
      5'd13: t = 10'd45;
      5'd14: t = 10'd54;
      5'd15: t = 10'd64;
      5'd16: t = 10'd76;
      5'd17: t = 10'd90;
      5'd18: t = 10'd108;
      5'd19: t = 10'd128;
      5'd20: t = 10'd152;
      5'd21: t = 10'd181;
      5'd22: t = 10'd215;
      5'd23: t = 10'd256;
      5'd24: t = 10'd304;
      5'd25: t = 10'd362;
      5'd26: t = 10'd430;
      5'd27: t = 10'd512;
      5'd28: t = 10'd608;
      5'd29: t = 10'd723;
      5'd30: t = 10'd860;
      default: t = 10'd1023;
    endcase
    return t;
  endfunction

  logic [5*CH-1:0] map_flat;
  logic [4:0]      m_sel;

  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_a;
  logic [IW-1:0]   idx_b;
  logic [4:0]      m_r;
  logic [9:0]      lin_r;
  logic            va;
  logic            vb;
  logic [SW-1:0]   acc;

  // Per-channel level mapping; 4-bit volumes land on odd table entries
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_map
      logic [4:0] m;
      always_comb begin
        m = lvl[5*gi +: 5];
        if (mute[gi]) begin
          m = 5'd0;
        end else if (mode[gi]) begin
          m = (lvl[5*gi +: 4] == 4'd0) ? 5'd0 : {lvl[5*gi +: 4], 1'b1};
        end
      end
      assign map_flat[5*gi +: 5] = m;
    end
  endgenerate

  always_comb begin
    m_sel = 5'd0;
    for (int c = 0; c < CH; c++) begin
      if (idx == IW'(c)) m_sel = map_flat[5*c +: 5];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      idx_a  <= '0;
      idx_b  <= '0;
      m_r    <= 5'd0;
      lin_r  <= 10'd0;
      va     <= 1'b0;
      vb     <= 1'b0;
      acc    <= '0;
      dout   <= '0;
      sample <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cen) begin
        // stage A
        m_r   <= m_sel;
        idx_a <= idx;
        va    <= 1'b1;
        idx   <= (idx == LAST) ? '0 : idx + 1'b1;
        // stage B
        lin_r <= lin_tab(m_r);
        idx_b <= idx_a;
        vb    <= va;
        // stage C
        if (vb) begin
          acc <= (idx_b == '0) ? SW'(lin_r) : acc + SW'(lin_r);
          if (idx_b == LAST) begin
            dout   <= ((idx_b == '0) ? '0 : acc) + SW'(lin_r);
            sample <= 1'b1;
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_lin
      logic [9:0] lin_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lin_q <= 10'd0;
        end else if (cen && vb && idx_b == IW'(gi)) begin
          lin_q <= lin_r;
        end
      end
      assign ch_lin[10*gi +: 10] = lin_q;
    end
  endgenerate

endmodule

// File: tb/tb_jt49_exp_mix.sv
// Randomised and directed bench for jt49_exp_mix against a queue-based
// model built directly from the level-mapping and table formula.
module tb_jt49_exp_mix;
  localparam int CH = 3;
  localparam int SW = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cen = 1'b0;
  logic [5*CH-1:0]   lvl = '0;
  logic [CH-1:0]     mode = '0;
  logic [CH-1:0]     mute = '0;
  logic [10*CH-1:0]  ch_lin;
  logic [SW-1:0]     dout;
  logic              sample;

  jt49_exp_mix #(.CH(CH), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .lvl(lvl), .mode(mode),
    .mute(mute), .ch_lin(ch_lin), .dout(dout), .sample(sample)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int tbl[32];

  int exp_lin[CH];
  int exp_dout;
  int exp_sample;
  int cen_n;
  int pend_ch[$];
  int pend_val[$];
  int landed[$];
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int map_lvl(input int c);
    int v;
    if (mute[c]) return 0;
    if (!mode[c]) return int'(lvl[5*c +: 5]);
    v = int'(lvl[5*c +: 4]);
    return (v == 0) ? 0 : 2 * v + 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) exp_lin[c] = 0;
    exp_dout = 0;
    exp_sample = 0;
    cen_n = 0;
    pend_ch.delete();
    pend_val.delete();
    landed.delete();
  endtask

  // A level sampled on one cen appears two cens later; a scan's sum is
  // published when its last channel appears.
  task automatic model_edge();
    int c, v, s;
    exp_sample = 0;
    if (!rst_n || !cen) return;
    if (pend_ch.size() == 2) begin
      c = pend_ch.pop_front();
      v = pend_val.pop_front();
      exp_lin[c] = v;
      landed.push_back(v);
      if (landed.size() > CH) void'(landed.pop_front());
      if (c == CH - 1) begin
        s = 0;
        foreach (landed[i]) s += landed[i];
        exp_dout = s;
        exp_sample = 1;
      end
    end
    c = cen_n % CH;
    pend_ch.push_back(c);
    pend_val.push_back(tbl[map_lvl(c)]);
    cen_n++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", int'(dout), exp_dout);
      chk("sample", int'(sample), exp_sample);
      for (int c = 0; c < CH; c++)
        chk($sformatf("ch_lin[%0d]", c), int'(ch_lin[10*c +: 10]), exp_lin[c]);
    end
  end

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_cens(input int n);
    cen = 1'b1;
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic wait_sample(output int ncen, input int budget);
    ncen = 0;
    cen = 1'b1;
    for (int i = 0; i < budget; i++) begin
      run_cycle();
      ncen++;
      if (sample) return;
    end
    chk("sample_timeout", 0, 1);
  endtask

  task automatic set_lvls(input int l0, input int l1, input int l2);
    lvl[4:0]   = 5'(l0);
    lvl[9:5]   = 5'(l1);
    lvl[14:10] = 5'(l2);
  endtask

  int n, k, t_last, t_prev;

  initial begin
    tbl[0] = 0;
    for (int i = 1; i < 32; i++)
      tbl[i] = int'($floor(1023.0 * (2.0 ** ((i - 31) / 4.0)) + 0.5));
    chk("T[31]", tbl[31], 1023);
    chk("T[30]", tbl[30], 860);
    chk("T[29]", tbl[29], 723);
    chk("T[27]", tbl[27], 512);
    chk("T[23]", tbl[23], 256);
    chk("T[15]", tbl[15], 64);
    chk("T[1]",  tbl[1],  6);

    // reset and start-up
    #1 rst_n = 1'b0;
    model_reset();
    set_lvls(31, 31, 31);
    run_cycle();
    run_cycle();
    chk_en = 1'b1;
    chk("reset_dout", int'(dout), 0);
    chk("reset_sample", int'(sample), 0);
    rst_n = 1'b1;
    wait_sample(n, 20);
    chk("first_sample_cen", n, CH + 2);
    chk("startup_dout", int'(dout), 3069);
    wait_sample(n, 10);
    chk("sample_period", n, CH);

    // 4-bit volume mode
    mode = '1;
    set_lvls(15, 14, 0);
    run_cens(9);
    chk("vol_ch0", int'(ch_lin[9:0]), 1023);
    chk("vol_ch1", int'(ch_lin[19:10]), 723);
    chk("vol_ch2", int'(ch_lin[29:20]), 0);
    chk("vol_dout", int'(dout), 1746);
    set_lvls(1, 14, 0);
    run_cens(9);
    chk("vol1_ch0", int'(ch_lin[9:0]), tbl[3]);

    // mute
    mode = '0;
    set_lvls(31, 31, 31);
    mute = 3'b010;
    run_cens(9);
    chk("mute_ch1", int'(ch_lin[19:10]), 0);
    chk("mute_dout", int'(dout), 2046);
    mute = '0;
    run_cens(9);
    chk("unmute_dout", int'(dout), 3069);

    // full table sweep on channel 0
    for (int i = 0; i < 32; i++) begin
      set_lvls(i, 0, 0);
      run_cens(9);
      chk($sformatf("sweep_lin[%0d]", i), int'(ch_lin[9:0]), tbl[i]);
      chk($sformatf("sweep_dout[%0d]", i), int'(dout), tbl[i]);
    end

    // sparse clock enable, one clk in four
    set_lvls(27, 23, 15);
    for (int i = 0; i < 48; i++) begin
      cen = (i % 4 == 0);
      run_cycle();
    end
    t_last = -1;
    t_prev = -1;
    for (int i = 0; i < 60; i++) begin
      cen = (i % 4 == 0);
      run_cycle();
      if (sample) begin
        t_prev = t_last;
        t_last = i;
      end
    end
    chk("sparse_period", t_last - t_prev, 12);
    chk("sparse_dout", int'(dout), 832);

    // reset one cen after a sample
    wait_sample(n, 10);
    run_cens(1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_ch0", int'(ch_lin[9:0]), 0);
    chk("midrst_sample", int'(sample), 0);
    run_cycle();
    rst_n = 1'b1;
    wait_sample(n, 20);
    chk("midrst_first_sample", n, 5);
    chk("midrst_sum", int'(dout), 832);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cen  = ($urandom_range(0, 3) != 0);
      lvl  = (5*CH)'($urandom);
      mode = CH'($urandom);
      mute = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        run_cycle();
        rst_n = 1'b1;
      end
      run_cycle();
    end

    chk_en = 1'b0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
